// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// Multi-mode video timing generator (1080p60 / 720p60 / 480p60 / custom) producing hs/vs/de and active coordinates.
// Define VTG_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module video_timing_gen #(
  parameter int X_BITS    = 12,
  parameter int Y_BITS    = 12,
  parameter int C_H_TOTAL = 1344,
  parameter int C_H_SYNC  = 136,
  parameter int C_H_BP    = 160,
  parameter int C_H_ACT   = 1024,
  parameter int C_V_TOTAL = 806,
  parameter int C_V_SYNC  = 6,
  parameter int C_V_BP    = 29,
  parameter int C_V_ACT   = 768,
  parameter int C_HS_POL  = 0,
  parameter int C_VS_POL  = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [1:0]        mode_sel,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [X_BITS-1:0] x_act,
  output logic [Y_BITS-1:0] y_act,
  output logic              frame_start,
  output logic [1:0]        mode_cur,
  output logic [15:0]       frame_cnt
);

  localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);

  logic [X_BITS-1:0] h_cnt, h_total, h_sync, h_bp, h_act, h_start, h_end;
  logic [Y_BITS-1:0] v_cnt, v_total, v_sync, v_bp, v_act, v_start, v_end;
  logic              hs_pol, vs_pol;
  logic              h_last, v_last, h_in, v_in, de_next;

  function automatic logic hs_pol_of(input logic [1:0] m);
    case (m)
      2'd0, 2'd1: return 1'b1;
      2'd2:       return 1'b0;
      default:    return (C_HS_POL != 0);
    endcase
  endfunction

  function automatic logic vs_pol_of(input logic [1:0] m);
    case (m)
      2'd0, 2'd1: return 1'b1;
      2'd2:       return 1'b0;
      default:    return (C_VS_POL != 0);
    endcase
  endfunction

  // Timing table for the mode currently applied; custom parameters are the fallback.
  always_comb begin
    h_total = X_BITS'(C_H_TOTAL);
    h_sync  = X_BITS'(C_H_SYNC);
    h_bp    = X_BITS'(C_H_BP);
    h_act   = X_BITS'(C_H_ACT);
    v_total = Y_BITS'(C_V_TOTAL);
    v_sync  = Y_BITS'(C_V_SYNC);
    v_bp    = Y_BITS'(C_V_BP);
    v_act   = Y_BITS'(C_V_ACT);
    case (mode_cur)
      2'd0: begin
        h_total = X_BITS'(2200); h_sync = X_BITS'(44); h_bp = X_BITS'(148); h_act = X_BITS'(1920);
        v_total = Y_BITS'(1125); v_sync = Y_BITS'(5);  v_bp = Y_BITS'(36);  v_act = Y_BITS'(1080);
      end
      2'd1: begin
        h_total = X_BITS'(1650); h_sync = X_BITS'(40); h_bp = X_BITS'(220); h_act = X_BITS'(1280);
        v_total = Y_BITS'(750);  v_sync = Y_BITS'(5);  v_bp = Y_BITS'(20);  v_act = Y_BITS'(720);
      end
      2'd2: begin
        h_total = X_BITS'(800);  h_sync = X_BITS'(96); h_bp = X_BITS'(48);  h_act = X_BITS'(640);
        v_total = Y_BITS'(525);  v_sync = Y_BITS'(2);  v_bp = Y_BITS'(33);  v_act = Y_BITS'(480);
      end
      default: ;
    endcase
  end

  assign hs_pol  = hs_pol_of(mode_cur);
  assign vs_pol  = vs_pol_of(mode_cur);
  assign h_start = h_sync + h_bp;
  assign h_end   = h_start + h_act;
  assign v_start = v_sync + v_bp;
  assign v_end   = v_start + v_act;
  assign h_last  = (h_cnt == h_total - X_ONE);
  assign v_last  = (v_cnt == v_total - Y_ONE);
  assign h_in    = (h_cnt >= h_start) && (h_cnt < h_end);
  assign v_in    = (v_cnt >= v_start) && (v_cnt < v_end);
  assign de_next = h_in && v_in;

  // Raster counters; mode_cur only moves on the last pixel of a frame, or freely while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      mode_cur <= 2'd0;
    end else if (!en) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      mode_cur <= mode_sel;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + Y_ONE;
      end else begin
        h_cnt <= h_cnt + X_ONE;
      end
      if (h_last && v_last)
        mode_cur <= mode_sel;
    end
  end

  // Registered decode; the idle sync level tracks the mode being loaded so it agrees with mode_cur.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      de_out      <= 1'b0;
      x_act       <= '0;
      y_act       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hs_out      <= ~hs_pol_of(mode_sel);
      vs_out      <= ~vs_pol_of(mode_sel);
      de_out      <= 1'b0;
      x_act       <= '0;
      y_act       <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_out      <= (h_cnt < h_sync) ? hs_pol : ~hs_pol;
      vs_out      <= (v_cnt < v_sync) ? vs_pol : ~vs_pol;
      de_out      <= de_next;
      x_act       <= de_next ? h_cnt - h_start : '0;
      y_act       <= de_next ? v_cnt - v_start : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef VTG_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      frame_cnt <= 16'd0;
    else if (en && frame_start)
      frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Randomised self-checking bench for video_timing_gen against a per-pixel raster reference model.
// Uses a small custom mode (mode 3) so whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int CHT = 48, CHS = 4, CHB = 6, CHA = 30;
  localparam int CVT = 20, CVS = 3, CVB = 2, CVA = 12;
  localparam int CHP = 1, CVP = 0;

  localparam int H_T[4] = '{2200, 1650, 800, CHT};
  localparam int H_S[4] = '{44, 40, 96, CHS};
  localparam int H_B[4] = '{148, 220, 48, CHB};
  localparam int H_A[4] = '{1920, 1280, 640, CHA};
  localparam int V_T[4] = '{1125, 750, 525, CVT};
  localparam int V_S[4] = '{5, 5, 2, CVS};
  localparam int V_B[4] = '{36, 20, 33, CVB};
  localparam int V_A[4] = '{1080, 720, 480, CVA};
  localparam int H_P[4] = '{1, 1, 0, CHP};
  localparam int V_P[4] = '{1, 1, 0, CVP};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        hs_out, vs_out, de_out, frame_start;
  logic [11:0] x_act, y_act;
  logic [1:0]  mode_cur;
  logic [15:0] frame_cnt;

  video_timing_gen #(
    .X_BITS(12), .Y_BITS(12),
    .C_H_TOTAL(CHT), .C_H_SYNC(CHS), .C_H_BP(CHB), .C_H_ACT(CHA),
    .C_V_TOTAL(CVT), .C_V_SYNC(CVS), .C_V_BP(CVB), .C_V_ACT(CVA),
    .C_HS_POL(CHP), .C_VS_POL(CVP)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode_sel(mode_sel),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .x_act(x_act), .y_act(y_act), .frame_start(frame_start),
    .mode_cur(mode_cur), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Reference raster position / mode and the outputs expected after the next edge.
  int mH, mV, mMode;
  int eHs, eVs, eDe, eX, eY, eFs, eFcnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mH = 0; mV = 0; mMode = 0;
    eHs = 0; eVs = 0; eDe = 0; eX = 0; eY = 0; eFs = 0; eFcnt = 0;
  endtask

  task automatic modelStep();
    int hStart, vStart;
    bit lastPix;
    if (!rstn) begin
      modelReset();
    end else begin
`ifdef VTG_FRAME_CNT_EN
      if (en && eFs == 1) eFcnt = (eFcnt + 1) % 65536;
`endif
      if (!en) begin
        mMode = int'(mode_sel);
        eHs = 1 - H_P[mMode]; eVs = 1 - V_P[mMode];
        eDe = 0; eX = 0; eY = 0; eFs = 0;
        mH = 0; mV = 0;
      end else begin
        hStart = H_S[mMode] + H_B[mMode];
        vStart = V_S[mMode] + V_B[mMode];
        eHs = (mH < H_S[mMode]) ? H_P[mMode] : 1 - H_P[mMode];
        eVs = (mV < V_S[mMode]) ? V_P[mMode] : 1 - V_P[mMode];
        eDe = (mH >= hStart && mH < hStart + H_A[mMode] &&
               mV >= vStart && mV < vStart + V_A[mMode]) ? 1 : 0;
        eX  = eDe ? mH - hStart : 0;
        eY  = eDe ? mV - vStart : 0;
        eFs = (mH == 0 && mV == 0) ? 1 : 0;
        lastPix = (mH == H_T[mMode] - 1) && (mV == V_T[mMode] - 1);
        mH = mH + 1;
        if (mH == H_T[mMode]) begin
          mH = 0;
          mV = (mV + 1) % V_T[mMode];
        end
        if (lastPix) mMode = int'(mode_sel);
      end
    end
  endtask

  task automatic checkAllOutputs();
    checkOutput("hs_out", hs_out, eHs);
    checkOutput("vs_out", vs_out, eVs);
    checkOutput("de_out", de_out, eDe);
    checkOutput("x_act", x_act, eX);
    checkOutput("y_act", y_act, eY);
    checkOutput("frame_start", frame_start, eFs);
    checkOutput("mode_cur", mode_cur, mMode);
    checkOutput("frame_cnt", frame_cnt, eFcnt);
  endtask

  // Called at a falling edge: drive inputs, advance the model across the next rising edge, then check.
  task automatic applyStimulus(input logic e, input logic [1:0] m);
    en = e;
    mode_sel = m;
    modelStep();
    @(negedge clk);
    checkAllOutputs();
  endtask

  task automatic asyncReset();
    #2 rstn = 1'b0;
    modelReset();
    #1 checkAllOutputs();
    checkOutput("rst_mode_cur", mode_cur, 0);
    @(negedge clk);
    checkAllOutputs();
    rstn = 1'b1;
  endtask

  function automatic logic [1:0] pickMode();
    if ($urandom_range(0, 7) < 5) return 2'd3;
    return 2'($urandom_range(0, 2));
  endfunction

  initial begin
    int deCount, hsLow, vsLow, firstDe, r, len;
    logic [1:0] curSel;

    modelReset();
    @(negedge clk);
    checkAllOutputs();
    applyStimulus(1'b1, 2'd0);
    rstn = 1'b1;

    // Custom mode, three whole frames, mode_sel scrambled except on the last line.
    applyStimulus(1'b0, 2'd3);
    applyStimulus(1'b0, 2'd3);
    deCount = 0;
    for (int k = 0; k < 3 * CHT * CVT; k++) begin
      applyStimulus(1'b1, (mV == CVT - 1) ? 2'd3 : 2'($urandom_range(0, 3)));
      if (de_out) deCount++;
    end
    checkOutput("de_count_3frames", deCount, 3 * CHA * CVA);
`ifdef VTG_FRAME_CNT_EN
    checkOutput("frame_cnt_3frames", frame_cnt, 3);
`else
    checkOutput("frame_cnt_tied", frame_cnt, 0);
`endif

    // Drop en inside the active area for 10 clocks.
    for (int k = 0; k < 1000 && !(mV == 5 && mH == 15); k++) applyStimulus(1'b1, 2'd3);
    checkOutput("wait_en_point", mV * 100 + mH, 515);
    applyStimulus(1'b0, 2'd3);
    checkOutput("en_off_de", de_out, 0);
    checkOutput("en_off_x", x_act, 0);
    checkOutput("en_off_y", y_act, 0);
    checkOutput("en_off_vs_idle", vs_out, 1);
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, 2'd3);
    applyStimulus(1'b1, 2'd3);
    checkOutput("en_on_frame_start", frame_start, 1);

    // Request 480p mid-frame; it must only apply at the frame boundary.
    for (int k = 0; k < 2000 && mV != 10; k++) applyStimulus(1'b1, 2'd3);
    checkOutput("wait_v10", mV, 10);
    for (int k = 0; k < 2000 && mMode != 2; k++) applyStimulus(1'b1, 2'd2);
    checkOutput("wait_mode2", mMode, 2);
    hsLow = 0; vsLow = 0; firstDe = -1;
    for (int k = 1; k <= 35 * 800 + 145; k++) begin
      applyStimulus(1'b1, 2'd2);
      if (!hs_out) hsLow++;
      if (!vs_out) vsLow++;
      if (de_out && firstDe < 0) firstDe = k;
    end
    checkOutput("m2_first_de", firstDe, 35 * 800 + 145);
    checkOutput("m2_hs_low", hsLow, 36 * 96);
    checkOutput("m2_vs_low", vsLow, 2 * 800);

    // 1080p start, then asynchronous reset at line 1, h=1000.
    applyStimulus(1'b0, 2'd0);
    applyStimulus(1'b0, 2'd0);
    for (int k = 0; k < 2200 + 1000; k++) applyStimulus(1'b1, 2'd0);
    asyncReset();
    applyStimulus(1'b1, 2'd0);
    checkOutput("rst_release_fs", frame_start, 1);
    checkOutput("rst_release_mode", mode_cur, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 2'd0);

    // Random run: mode_sel changes, en drops and occasional resets.
    curSel = 2'd3;
    applyStimulus(1'b0, curSel);
    for (int k = 0; k < 28000; k++) begin
      r = $urandom_range(0, 9999);
      if (r < 5) begin
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
          curSel = pickMode();
          applyStimulus(1'b0, curSel);
        end
      end else if (r < 7) begin
        asyncReset();
        applyStimulus(1'b1, curSel);
      end else begin
        if ($urandom_range(0, 49) == 0) curSel = pickMode();
        applyStimulus(1'b1, curSel);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised multi-mode video timing generator for the HDMI output path. It supersedes the fixed single-mode sync generator and produces hs/vs/de plus active-area coordinates for 1080p60, 720p60, 480p60 or a parameter-defined custom mode. The mode is selectable at run time and changes only on frame boundaries. It sits between the PLL/reset logic and the pattern or frame-buffer readout stage, clocked by the pixel clock.

## Interface

**Parameters**

- X_BITS, 12: width of the horizontal counter and of x_act.
- Y_BITS, 12: width of the vertical counter and of y_act.
- C_H_TOTAL / C_H_SYNC / C_H_BP / C_H_ACT, 1344 / 136 / 160 / 1024: custom-mode (mode 3) horizontal timing.
- C_V_TOTAL / C_V_SYNC / C_V_BP / C_V_ACT, 806 / 6 / 29 / 768: custom-mode vertical timing.
- C_HS_POL / C_VS_POL, 0 / 0: custom-mode sync polarity; 1 = active-high.

**Ports**

- clk  in  1  pixel clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- mode_sel  in  2  0 = 1080p, 1 = 720p, 2 = 480p, 3 = custom.
- hs_out  out  1  horizontal sync, at the active mode's polarity.
- vs_out  out  1  vertical sync, at the active mode's polarity.
- de_out  out  1  data enable.
- x_act  out  X_BITS  active pixel column; 0 outside the active area.
- y_act  out  Y_BITS  active line; 0 outside the active area.
- frame_start  out  1  one-cycle pulse coincident with h=0, v=0.
- mode_cur  out  2  currently applied mode.
- frame_cnt  out  16  frame counter (see Configuration).

## Operation

**Mode table** (H_TOTAL / H_SYNC / H_BP / H_ACT ; V_TOTAL / V_SYNC / V_BP / V_ACT ; polarity):

- Mode 0: 2200/44/148/1920 ; 1125/5/36/1080 ; positive.
- Mode 1: 1650/40/220/1280 ; 750/5/20/720 ; positive.
- Mode 2: 800/96/48/640 ; 525/2/33/480 ; negative.
- Mode 3: C_* parameters.
- Front porch is implicit: TOTAL − SYNC − BP − ACT.

**Counters**

- h_cnt counts 0..H_TOTAL−1. On wrap, v_cnt increments; v_cnt wraps after V_TOTAL−1.

**Decode (per cycle, from counters)**

- hs is active while h_cnt < H_SYNC.
- vs is active while v_cnt < V_SYNC.
- de is 1 while h_cnt ∈ [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_cnt ∈ [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
- When de is 1: x_act = h_cnt − (H_SYNC+H_BP) and y_act = v_cnt − (V_SYNC+V_BP). Both are computed at X_BITS/Y_BITS with no overflow, since all tables fit in 12 bits.

**Mode switch**

- mode_sel is sampled into mode_cur only on the last cycle of a frame (h = H_TOTAL−1, v = V_TOTAL−1). The new timing takes effect at h=0, v=0 of the next frame.
- Changes to mode_sel mid-frame are ignored until the frame ends; only the last value present at the boundary is applied.

**Enable**

- en low forces both counters to 0 on the next edge, drives all outputs to their inactive values, and lets mode_cur load mode_sel every cycle.
- en rising starts a frame at h=0, v=0, and frame_start pulses.

## Timing

- **Reset values:** counters 0; mode_cur = 0; hs_out/vs_out at mode 0 inactive level (0); de_out 0; x_act 0; y_act 0; frame_start 0; frame_cnt 0.
- **Latency:** every output is registered, so outputs lag the counters by exactly 1 clk. hs_out, vs_out, de_out, x_act, y_act and frame_start stay mutually aligned.
- **Polarity:** follows mode_cur. Polarity changes only at the frame boundary, so no glitch occurs mid-frame.
- **Asynchronous reset mid-frame:** outputs return to their reset values immediately. After release, the first frame starts from h=0, v=0 with mode 0.
- **Simultaneous en fall and frame boundary:** en wins. Counters go to 0, and mode_cur loads mode_sel.

## Configuration

- **Macro VTG_FRAME_CNT_EN defined:**
  - frame_cnt increments by 1 on each cycle where frame_start is 1, wrapping 16'hFFFF→0.
  - It clears on reset and holds its value while en is low.
- **Macro undefined:** the frame_cnt port still exists, is tied to 0, and has no counter logic.

## Test plan

- **Mode 0 free-run:** reset, en=1, mode_sel=0 → 2200 clk per line; 1125 lines per frame; de high for 1920×1080 cycles per frame; first de at h=192, v=41 (registered +1 clk); x_act runs 0..1919.
- **Mode 2 polarity:** mode_sel=2 from reset release, after 1 frame → hs_out low for 96 clk per 800; vs_out low for 2 lines per 525; 640×480 de cycles.
- **Mid-frame switch:** in mode 0, set mode_sel=1 at v=500 → mode_cur stays 0 until the frame end; next frame_start is followed by 1650-clk lines and 750 lines.
- **en toggle:** drop en at v=300 for 10 clk → outputs are inactive and x_act/y_act are 0 within 1 clk; on re-enable, frame_start pulses 1 clk after en rises.
- **Asynchronous reset mid-line:** assert rstn=0 between clk edges at h=1000 → outputs go to reset values before the next edge; mode_cur = 0.
- **VTG_FRAME_CNT_EN:** preload via 3 complete frames → frame_cnt = 3; without the macro, frame_cnt = 0 throughout.
